// File: rtl/interp_sweep_drv.sv
// Drives an external fixed-latency interpolator across an x sweep and collects
// its results, with credit-based issue so the result FIFO can never overflow.
module interp_sweep_drv #(
   parameter int XW      = 8,
   parameter int WW      = 12,
   parameter int YW      = 12,
   parameter int DUT_LAT = 3,
   parameter int DEPTH   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_addr,
   input  logic [WW-1:0] cfg_wdata,
   input  logic          start,
   input  logic [XW-1:0] x_start,
   input  logic [XW-1:0] x_step,
   input  logic [XW:0]   x_count,
   output logic          busy,
   output logic          done,
   output logic          o_en,
   output logic [XW-1:0] o_x,
   output logic [WW-1:0] o_weight0,
   output logic [WW-1:0] o_weight1,
   output logic [WW-1:0] o_weight2,
   output logic [WW-1:0] o_weight3,
   output logic [WW-1:0] o_weight4,
   output logic [WW-1:0] o_weight5,
   output logic [WW-1:0] o_weight6,
   output logic [WW-1:0] o_weight7,
   input  logic [YW-1:0] i_y,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [XW-1:0] m_x,
   output logic [YW-1:0] m_y,
   output logic          m_last
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t        state, state_nxt;
   logic [WW-1:0] wtab [8];
   logic [XW-1:0] cur_x, step_x, hold_x;
   logic [XW:0]   remain;
   logic [CW-1:0] inflight, occ;
   logic [CW:0]   load;
   logic          credit, issue, push, pop;

   logic [DUT_LAT-1:0] dl_v, dl_l;
   logic [XW-1:0]      dl_x [DUT_LAT];

   logic [XW-1:0] f_x [DEPTH];
   logic [YW-1:0] f_y [DEPTH];
   logic          f_l [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;

   assign o_weight0 = wtab[0];
   assign o_weight1 = wtab[1];
   assign o_weight2 = wtab[2];
   assign o_weight3 = wtab[3];
   assign o_weight4 = wtab[4];
   assign o_weight5 = wtab[5];
   assign o_weight6 = wtab[6];
   assign o_weight7 = wtab[7];

   // Credit covers samples still inside the interpolator as well as queued ones.
   assign load    = {1'b0, inflight} + {1'b0, occ};
   assign credit  = load < (CW+1)'(DEPTH);
   assign push    = dl_v[DUT_LAT-1];
   assign m_valid = (occ != '0);
   assign pop     = m_valid && m_ready;

   assign busy = (state == ISSUE) || (state == DRAIN);
   assign done = (state == DONE);
   assign o_en = issue;
   assign o_x  = issue ? cur_x : hold_x;

   assign m_x    = m_valid ? f_x[rd_ptr] : '0;
   assign m_y    = m_valid ? f_y[rd_ptr] : '0;
   assign m_last = m_valid && f_l[rd_ptr];

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (x_count != '0) ? ISSUE : DONE;
         end
         ISSUE: begin
            if (credit) begin
               issue = 1'b1;
               if (remain == (XW+1)'(1)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Leave as the final entry pops so done follows the last pop directly.
            if (inflight == '0 && (occ == '0 || (occ == CW'(1) && pop)))
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_x    <= '0;
         step_x   <= '0;
         hold_x   <= '0;
         remain   <= '0;
         inflight <= '0;
         occ      <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         dl_v     <= '0;
         dl_l     <= '0;
         for (int i = 0; i < 8; i++) wtab[i] <= '0;
         for (int k = 0; k < DUT_LAT; k++) dl_x[k] <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cfg_we) wtab[cfg_addr] <= cfg_wdata;
         if (state == IDLE && start && x_count != '0) begin
            cur_x  <= x_start;
            step_x <= x_step;
            remain <= x_count;
         end
         if (issue) begin
            hold_x <= cur_x;
            cur_x  <= cur_x + step_x;
            remain <= remain - (XW+1)'(1);
         end
         for (int k = DUT_LAT-1; k > 0; k--) begin
            dl_v[k] <= dl_v[k-1];
            dl_l[k] <= dl_l[k-1];
            dl_x[k] <= dl_x[k-1];
         end
         dl_v[0]  <= issue;
         dl_l[0]  <= issue && (remain == (XW+1)'(1));
         dl_x[0]  <= o_x;
         inflight <= inflight + CW'(issue) - CW'(push);
         occ      <= occ + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         f_x[wr_ptr] <= dl_x[DUT_LAT-1];
         f_y[wr_ptr] <= i_y;
         f_l[wr_ptr] <= dl_l[DUT_LAT-1];
      end
   end

endmodule

// File: tb/tb_interp_sweep_drv.sv
// Bench for interp_sweep_drv: a latency-L interpolator model returns random y,
// and results are checked in order against the sweep's arithmetic x sequence.
module tb_interp_sweep_drv;

   localparam int XW = 8, WW = 12, YW = 12, L = 3, DEPTH = 8;
   localparam int EW = 1 + XW + YW;

   logic          clk = 0, rst = 1, cfg_we = 0, start = 0, m_ready = 1;
   logic [2:0]    cfg_addr = 0;
   logic [WW-1:0] cfg_wdata = 0;
   logic [XW-1:0] x_start = 0, x_step = 0;
   logic [XW:0]   x_count = 0;
   logic [YW-1:0] i_y;
   logic          busy, done, o_en, m_valid, m_last;
   logic [XW-1:0] o_x, m_x;
   logic [YW-1:0] m_y;
   logic [WW-1:0] w_out [8];

   interp_sweep_drv #(.XW(XW), .WW(WW), .YW(YW), .DUT_LAT(L), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .start(start), .x_start(x_start), .x_step(x_step), .x_count(x_count),
      .busy(busy), .done(done), .o_en(o_en), .o_x(o_x),
      .o_weight0(w_out[0]), .o_weight1(w_out[1]), .o_weight2(w_out[2]), .o_weight3(w_out[3]),
      .o_weight4(w_out[4]), .o_weight5(w_out[5]), .o_weight6(w_out[6]), .o_weight7(w_out[7]),
      .i_y(i_y), .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_last(m_last)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;
   int sweep_issues = 0, first_iss_cyc = 0, last_iss_cyc = 0;
   int pops = 0, pop_cyc = 0, dones = 0, done_cyc = 0, valid_cycles = 0;
   logic [XW:0]   iss_q[$];
   logic [EW-1:0] exp_q[$];
   logic [WW-1:0] wt_model [8];
   logic [YW-1:0] sh [L];
   logic          hold_pend = 0;
   logic [EW-1:0] held = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // interpolator model and scoreboard monitor, sampled mid-cycle
   always @(negedge clk) begin
      logic [YW-1:0] y_new;
      logic [XW:0]   e;
      logic [EW-1:0] got, want;
      i_y = sh[L-1];
      for (int k = L-1; k > 0; k--) sh[k] = sh[k-1];
      y_new = YW'($urandom);
      sh[0] = y_new;
      got = {m_last, m_x, m_y};
      if (rst) begin
         iss_q.delete();
         exp_q.delete();
         hold_pend = 0;
      end else begin
         if (o_en) begin
            sweep_issues++;
            last_iss_cyc = cyc;
            if (sweep_issues == 1) first_iss_cyc = cyc;
            if (iss_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_issue: o_x 0x%0h, expected no issue (cycle %0d)", o_x, cyc);
            end else begin
               e = iss_q.pop_front();
               chk("o_x", o_x, e[XW-1:0]);
               exp_q.push_back({e[XW], e[XW-1:0], y_new});
            end
         end
         if (hold_pend) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", got, held);
         end
         if (m_valid) valid_cycles++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_result: got 0x%0h, expected no result (cycle %0d)", got, cyc);
            end else begin
               want = exp_q.pop_front();
               chk("result", got, want);
            end
            pops++;
            pop_cyc = cyc;
         end
         hold_pend = m_valid && !m_ready;
         held = got;
         if (done) begin
            dones++;
            done_cyc = cyc;
         end
      end
   end

   // driver tasks (all start and end at posedge + 1)
   task automatic start_sweep(input logic [XW-1:0] xs, input logic [XW-1:0] st, input logic [XW:0] cnt);
      for (int i = 0; i < int'(cnt); i++) begin
         int v;
         logic [XW-1:0] xv;
         v = (int'(xs) + i * int'(st)) % (1 << XW);
         xv = XW'(v);
         iss_q.push_back({(i == int'(cnt) - 1), xv});
      end
      sweep_issues = 0;
      dones = 0;
      x_start = xs; x_step = st; x_count = cnt; start = 1;
      @(posedge clk); #1;
      start = 0;
      if (cnt != 0) chk("busy_after_start", busy, 1);
      else begin
         chk("done_zero_count", done, 1);
         chk("busy_zero_count", busy, 0);
      end
   endtask

   task automatic wait_done(input int mode, input bit poke);
      int n = 0;
      while (dones == 0 && n < 600) begin
         case (mode)
            0:       m_ready = 1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 0;
         endcase
         if (poke && n == 2) begin
            start = 1; x_start = XW'($urandom); x_count = 5;
            cfg_we = 1; cfg_addr = 3'($urandom); cfg_wdata = WW'($urandom);
         end else begin
            start = 0; cfg_we = 0;
         end
         @(posedge clk); #1;
         n++;
      end
      start = 0; cfg_we = 0;
      chk("done_count", dones, 1);
      chk("issue_q_empty", iss_q.size(), 0);
      chk("result_q_empty", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("idle_not_busy", busy, 0);
   endtask

   task automatic check_weights(input string nm);
      for (int i = 0; i < 8; i++) chk(nm, w_out[i], wt_model[i]);
   endtask

   task automatic run_sweep(input logic [XW-1:0] xs, input logic [XW-1:0] st, input logic [XW:0] cnt,
                            input int mode, input bit poke);
      int pops_before = pops;
      start_sweep(xs, st, cnt);
      wait_done(mode, poke);
      chk("pop_count", pops - pops_before, cnt);
      if (cnt != 0) chk("done_after_last_pop", done_cyc, pop_cyc + 1);
      check_weights("weights_after_sweep");
   endtask

   initial begin
      int n, pops_before, vc;
      int wvals [8] = '{104, 235, 293, 439, 595, 662, 691, 694};
      for (int i = 0; i < 8; i++) wt_model[i] = '0;
      for (int k = 0; k < L; k++) sh[k] = '0;
      i_y = '0;

      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_o_en", o_en, 0);
      chk("rst_m_valid", m_valid, 0); chk("rst_m_last", m_last, 0); chk("rst_o_x", o_x, 0);
      chk("rst_m_x", m_x, 0); chk("rst_m_y", m_y, 0);
      check_weights("rst_weights");
      rst = 0;

      // weight table load
      for (int i = 0; i < 8; i++) begin
         cfg_we = 1; cfg_addr = 3'(i); cfg_wdata = WW'(wvals[i]);
         @(posedge clk); #1;
         wt_model[i] = WW'(wvals[i]);
         chk("weight_write", w_out[i], wt_model[i]);
      end
      cfg_we = 0;
      check_weights("weights_loaded");

      // basic sweep, zero backpressure
      run_sweep(24, 1, 4, 0, 0);
      chk("issue_span", last_iss_cyc - first_iss_cyc, 3);
      chk("issue_total", sweep_issues, 4);

      // x wraps modulo 2^XW
      run_sweep(250, 4, 3, 0, 0);

      // credit limit under full backpressure
      m_ready = 0;
      pops_before = pops;
      start_sweep(7, 5, 20);
      repeat (40) begin @(posedge clk); #1; end
      chk("credit_issues", sweep_issues, DEPTH);
      chk("credit_o_en_low", o_en, 0);
      chk("credit_m_valid", m_valid, 1);
      wait_done(0, 0);
      chk("credit_pop_count", pops - pops_before, 20);

      // reset in mid-sweep
      m_ready = 0;
      start_sweep(10, 3, 10);
      n = 0;
      while (sweep_issues < 5 && n < 50) begin @(posedge clk); #1; n++; end
      chk("five_issues_reached", sweep_issues >= 5, 1);
      rst = 1;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0); chk("abort_done", done, 0); chk("abort_o_en", o_en, 0);
      chk("abort_m_valid", m_valid, 0); chk("abort_m_last", m_last, 0); chk("abort_o_x", o_x, 0);
      chk("abort_m_x", m_x, 0); chk("abort_m_y", m_y, 0);
      for (int i = 0; i < 8; i++) wt_model[i] = '0;
      check_weights("abort_weights");
      rst = 0;
      dones = 0;
      vc = valid_cycles;
      repeat (20) begin @(posedge clk); #1; end
      chk("abort_no_done", dones, 0);
      chk("abort_no_valid", valid_cycles - vc, 0);
      m_ready = 1;

      // zero-length sweep
      vc = valid_cycles;
      run_sweep(5, 1, 0, 0, 0);
      chk("zero_count_no_valid", valid_cycles - vc, 0);

      // random sweeps with random backpressure; odd ones poke start/cfg_we while busy
      for (int r = 0; r < 6; r++) begin
         run_sweep(XW'($urandom), XW'($urandom), (XW+1)'($urandom_range(5, 30)), 1, r[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/interp_sweep_drv.md
INTERP_SWEEP_DRV -- requirements
Module: interp_sweep_drv

Interface
REQ-001 Parameters SHALL be: XW, default 8, x width; WW, default 12, weight width; YW, default 12, y width; DUT_LAT, default 3, fixed interpolator latency in cycles from en/x to y; DEPTH, default 8, result FIFO depth (power of 2).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  weight table write strobe.
- cfg_addr  in  3  weight index 0..7.
- cfg_wdata  in  WW  weight value.
- start  in  1  sweep start pulse.
- x_start  in  XW  first x of sweep.
- x_step  in  XW  x increment per sample.
- x_count  in  XW+1  number of samples.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle end-of-sweep pulse.
- o_en  out  1  interpolator enable.
- o_x  out  XW  interpolator x.
- o_weight0..o_weight7  out  WW each  interpolator weights.
- i_y  in  YW  interpolator result.
- m_valid  out  1  result valid.
- m_ready  in  1  result accept.
- m_x  out  XW  x that produced m_y.
- m_y  out  YW  captured result.
- m_last  out  1  final sample of sweep.

Function
REQ-003 The block SHALL hold an 8-entry weight table; o_weightN SHALL equal entry N at all times.
REQ-004 cfg_we while idle SHALL write cfg_wdata to entry cfg_addr on that edge; cfg_we while busy SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-006 IDLE->ISSUE on start with x_count>0: latch x_start, x_step, x_count; busy=1 from next cycle.
REQ-007 start with x_count=0 SHALL go IDLE->DONE, emitting no results.
REQ-008 start while busy SHALL be ignored.
REQ-009 ISSUE: per cycle, if credit available, drive o_en=1, o_x=current x, then x <= x+x_step mod 2^XW and decrement remaining; else o_en=0.
REQ-010 Credit SHALL be available when (issued-not-yet-captured + FIFO occupancy) < DEPTH; FIFO SHALL never overflow.
REQ-011 ISSUE->DRAIN after the last issue; DRAIN->DONE when nothing is in flight and the FIFO is empty.
REQ-012 DONE SHALL last one cycle with done=1, busy=0, then go to IDLE.
REQ-013 A DUT_LAT-deep valid/x/last delay line SHALL track issues; i_y SHALL be captured together with delayed x and last exactly DUT_LAT cycles after its o_en cycle.
REQ-014 The result FIFO SHALL present m_valid/m_x/m_y/m_last; an entry is popped on m_valid&&m_ready; m_x/m_y/m_last SHALL hold while m_valid&&!m_ready.
REQ-015 Simultaneous push and pop SHALL both occur, occupancy unchanged; push when full SHALL be impossible by REQ-010.
REQ-016 m_last SHALL be 1 only on the entry of the x_count-th sample.
REQ-017 Results SHALL leave in issue order; zero-backpressure throughput SHALL be one sample per cycle.
REQ-018 o_x SHALL hold its last value when o_en=0.

Reset
REQ-019 rst SHALL force state IDLE; busy, done, o_en, m_valid, m_last = 0; o_x, m_x, m_y = 0; all weight entries = 0; FIFO and delay line emptied.
REQ-020 rst mid-sweep SHALL abort the sweep with no done pulse; in-flight i_y values SHALL be discarded.

Verification
REQ-021 Write weights 104,235,293,439,595,662,691,694 to entries 0..7 -> o_weight0..7 show these values the next cycle.
REQ-022 x_start=24, x_step=1, x_count=4, m_ready=1 -> o_en high 4 consecutive cycles with o_x=24..27; m_x=24..27 each paired with the model's i_y, m_last on x=27; done exactly one cycle after the final pop.
REQ-023 x_start=250, x_step=4, x_count=3 -> o_x=250,254,2 (wrap).
REQ-024 x_count=20, m_ready=0 -> exactly 8 issues then o_en=0; m_ready=1 -> all 20 results in order, no loss or duplication.
REQ-025 Assert rst after 5 issues of a 10-sample sweep -> outputs at reset values next cycle; no done; m_valid=0 thereafter.
REQ-026 start with x_count=0 -> done pulse, m_valid=0 throughout; cfg_we during a busy sweep -> table unchanged.
